// File: rtl/aes_dec_iter.sv
// Iterative AES-128 straight inverse cipher: one LOAD cycle, then a SUB/MIX
// cycle pair per round, with round keys 10..0 pulled from an external store.
module aes_dec_iter #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam logic [3:0] NR4 = 4'(NR);

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [2:0] {IDLE, LOAD, SUB, MIX, DONE} fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [127:0] ct_q, st_q, tmp_q, key_q;
   logic [3:0]   round_q;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant using the x, x^2, x^4, x^8 partial products.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2, a4, a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[0] ? a : 8'h00);
   endfunction

   // Byte (row w, column c) lives at index 4c+w; row w rotates right by w.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 32] = {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                              gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                              gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                              gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fsm_q <= IDLE;
      else if (en)
         fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d     = fsm_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) fsm_d = LOAD;
         end
         LOAD: fsm_d = SUB;
         SUB:  fsm_d = MIX;
         MIX:  fsm_d = (round_q == 4'd0) ? DONE : SUB;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // rk_idx doubles as the key store's address register: rk_data must hold
   // the key for the current rk_idx by the next enabled edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ct_q    <= '0;
         st_q    <= '0;
         tmp_q   <= '0;
         key_q   <= '0;
         round_q <= '0;
         rk_idx  <= '0;
      end else if (en) begin
         case (fsm_q)
            IDLE: if (in_valid) begin
               ct_q   <= in_data;
               rk_idx <= NR4;
            end
            LOAD: begin
               st_q    <= ct_q ^ rk_data;
               round_q <= NR4 - 4'd1;
               rk_idx  <= NR4 - 4'd1;
            end
            SUB: begin
               tmp_q <= inv_sub_bytes(inv_shift_rows(st_q));
               key_q <= rk_data;
            end
            MIX: begin
               if (round_q != 4'd0) begin
                  st_q    <= inv_mix_columns(tmp_q ^ key_q);
                  rk_idx  <= round_q - 4'd1;
                  round_q <= round_q - 4'd1;
               end else begin
                  st_q <= tmp_q ^ key_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data = st_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Bench for aes_dec_iter: expected plaintexts come from FIPS-197 vectors and
// from a forward-cipher model (ciphertext = encrypt(random plaintext)).
module tb_aes_dec_iter;

   logic         clk = 1'b0;
   logic         rst, en, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_data, rk_data, out_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_mem [0:10];
   logic [7:0]   sbox [0:255];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   assign rk_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

   aes_dec_iter #(.NR(10)) dut (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rk_idx(rk_idx), .rk_data(rk_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   typedef struct packed {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      logic         tog;
      logic [7:0]   hold;
      logic [7:0]   lat;
   } vec_t;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = xt(a);
      end
      return p;
   endfunction

   // Forward S-box from first principles: multiplicative inverse then affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] p;
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, x);
      return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s, t;
      logic [7:0]   a [4];
      s = pt ^ rk_mem[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
         t = s;
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               s[127-8*(4*c+w) -: 8] = t[127-8*(4*((c+w)%4)+w) -: 8];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int w = 0; w < 4; w++) a[w] = s[127-8*(4*c+w) -: 8];
               s[127-32*c -: 32] = {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
                                    a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
                                    a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
                                    xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
            end
         end
         s = s ^ rk_mem[r];
      end
      return s;
   endfunction

   task automatic gen_block(output logic [127:0] ct, output logic [127:0] pt);
      for (int r = 0; r < 11; r++) rk_mem[r] = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(pt);
   endtask

   // One block: accept, count enabled/plain edges to out_valid, track rk_idx,
   // optionally stall the sink, then drain. Called at a negedge.
   task automatic do_block(input int id, input logic [127:0] ct, input logic [127:0] pt,
                           input logic tog, input int hold, input int lat);
      int         cyc;
      logic [3:0] prev;
      logic       mono, stable;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("v%0d in_ready idle", id), 128'(in_ready), 128'd1);
      en = 1'b1;
      in_valid = 1'b1;
      in_data = ct;
      @(negedge clk);
      in_valid = 1'b0;
      in_data = ~ct;
      chk($sformatf("v%0d rk_idx first", id), 128'(rk_idx), 128'd10);
      cyc = 0;
      mono = 1'b1;
      prev = rk_idx;
      while (!out_valid && cyc < 200) begin
         if (tog) en = ~en;
         @(negedge clk);
         cyc++;
         if (rk_idx > prev) mono = 1'b0;
         prev = rk_idx;
      end
      en = 1'b1;
      chk($sformatf("v%0d latency", id), 128'(cyc), 128'(lat));
      chk($sformatf("v%0d rk_idx monotone", id), 128'(mono), 128'd1);
      chk($sformatf("v%0d rk_idx last", id), 128'(rk_idx), 128'd0);
      chk($sformatf("v%0d out_data", id), out_data, pt);
      chk($sformatf("v%0d in_ready busy", id), 128'(in_ready), 128'd0);
      if (hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_data !== pt || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
         end
         chk($sformatf("v%0d hold stable", id), 128'(stable), 128'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d out_valid drop", id), 128'(out_valid), 128'd0);
      chk($sformatf("v%0d in_ready after", id), 128'(in_ready), 128'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vt [4];
      logic [127:0] ct, pt;
      int           t, last, bad_sp;

      vt[0] = '{key: K_C1, ct: CT_C1, pt: PT_C1, tog: 1'b0, hold: 8'd0,  lat: 8'd21};
      vt[1] = '{key: K_B,  ct: CT_B,  pt: PT_B,  tog: 1'b0, hold: 8'd50, lat: 8'd21};
      vt[2] = '{key: K_C1, ct: CT_C1, pt: PT_C1, tog: 1'b1, hold: 8'd0,  lat: 8'd42};
      vt[3] = '{key: K_B,  ct: CT_B,  pt: PT_B,  tog: 1'b1, hold: 8'd3,  lat: 8'd42};

      for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
      expand(K_C1);

      rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset in_ready", 128'(in_ready), 128'd0);
      chk("reset out_valid", 128'(out_valid), 128'd0);
      chk("reset out_data", out_data, 128'd0);
      chk("reset rk_idx", 128'(rk_idx), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset in_ready", 128'(in_ready), 128'd1);

      for (int v = 0; v < 4; v++) begin
         expand(vt[v].key);
         chk($sformatf("v%0d model encrypt", v), encrypt(vt[v].pt), vt[v].ct);
         do_block(v, vt[v].ct, vt[v].pt, vt[v].tog, int'(vt[v].hold), int'(vt[v].lat));
      end

      // Abort in the middle of round 5, then a clean block afterwards.
      expand(K_C1);
      in_valid = 1'b1;
      in_data = CT_C1;
      @(negedge clk);
      in_valid = 1'b0;
      t = 0;
      while (rk_idx != 4'd5 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("abort reached round 5", 128'(rk_idx), 128'd5);
      rst = 1'b1;
      #1;
      chk("abort out_valid", 128'(out_valid), 128'd0);
      chk("abort in_ready", 128'(in_ready), 128'd0);
      chk("abort out_data", out_data, 128'd0);
      chk("abort rk_idx", 128'(rk_idx), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort in_ready release", 128'(in_ready), 128'd1);
      @(negedge clk);
      expand(K_B);
      do_block(9, CT_B, PT_B, 1'b0, 0, 21);

      // Back-to-back random blocks, sink always ready; 23 cycles per block
      // (IDLE accept, LOAD, 10 x SUB/MIX, DONE transfer).
      out_ready = 1'b1;
      gen_block(ct, pt);
      in_data = ct;
      in_valid = 1'b1;
      last = -1;
      bad_sp = 0;
      for (int b = 0; b < 1000; b++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!out_valid && t < 60);
         chk($sformatf("rand blk %0d", b), out_data, pt);
         if (last >= 0 && cyc_cnt - last != 23) bad_sp++;
         last = cyc_cnt;
         if (b == 999) in_valid = 1'b0;
         else begin
            gen_block(ct, pt);
            in_data = ct;
         end
      end
      chk("rand spacing errors", 128'(bad_sp), 128'd0);
      out_ready = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
